// File: rtl/bsg_flow_credit_sender.sv
// bsg_flow_credit_sender
// Credit-gated output stage placed just upstream of bsg_flow_counter and the
// downstream FIFO it tracks. Producer words are held in a small circular
// buffer and offered downstream only while the flow counter reports a free
// slot. A RUN/DRAIN/DONE state machine lets software quiesce the path.
//
// Optional build macro: BSG_FLOW_CREDIT_SENDER_STATS_EN
//   adds stall_cycles_o, a saturating 16-bit count of cycles where the
//   buffer holds data but no downstream credit is available.
module bsg_flow_credit_sender #(
    parameter int width_p       = 32,
    parameter int els_p         = 4,
    parameter int count_width_p = 9
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic [width_p-1:0]       data_i,
    input  logic                     v_i,
    output logic                     ready_o,

    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    input  logic                     ready_i,

    input  logic [count_width_p-1:0] free_count_i,

    input  logic                     drain_i,
    output logic                     drain_done_o,
    output logic                     empty_o
`ifdef BSG_FLOW_CREDIT_SENDER_STATS_EN
    ,
    output logic [15:0]              stall_cycles_o
`endif
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_w:0] occ_full = (ptr_w + 1)'(els_p);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state, state_n;
    logic [ptr_w-1:0]   rd_ptr, wr_ptr;
    logic [ptr_w:0]     occ;
    logic [width_p-1:0] mem [els_p];

    logic enq, deq;
    logic has_data, has_credit;

    assign has_data   = (occ != '0);
    assign has_credit = (free_count_i != '0);

    // Producer side: accept only in RUN and only when a slot is free now.
    // No full-bypass, so a same-cycle send never opens ready_o. Reset gates
    // it directly so the producer sees backpressure while reset is held.
    assign ready_o = reset_n_i & (state == RUN) & (occ != occ_full);

    // Downstream side: offer the head word whenever there is credit; this
    // never looks at ready_i. free_count_i is registered in the counter, so
    // with at most one send per cycle a non-zero count is always safe.
    assign v_o    = has_data & has_credit;
    assign data_o = mem[rd_ptr];

    assign enq = v_i & ready_o;
    assign deq = v_o & ready_i;

    assign empty_o      = ~has_data;
    assign drain_done_o = (state == DONE);

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since els_p is 2^n.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({enq, deq})
                2'b10:   occ <= occ + (ptr_w + 1)'(1);
                2'b01:   occ <= occ - (ptr_w + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Drain state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Drain next-state: a drain, once started, runs until the buffer is
    // empty; holding drain_i high bounces DONE<->DRAIN so done pulses
    // every second cycle until the request is dropped.
    always_comb begin
        state_n = state;
        case (state)
            RUN: begin
                if (drain_i) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!has_data) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = drain_i ? DRAIN : RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

`ifdef BSG_FLOW_CREDIT_SENDER_STATS_EN
    logic [15:0] stall_cnt;
    logic        done_entry;

    assign done_entry = (state != DONE) && (state_n == DONE);

    // Credit-starvation counter: saturates, cleared when a drain completes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt <= '0;
        end else if (done_entry) begin
            stall_cnt <= '0;
        end else if (has_data && !has_credit && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
`endif

endmodule
